// File: rtl/debounce_array.sv
// Multi-channel pin debouncer: 2-flop synchroniser, stability counter, edge pulses and long-press detection.
// Define DEBOUNCE_ARRAY_REPEAT_EN to add auto-repeat pulses on o_rep after a long press.
module debounce_array #(
  parameter int N_CH     = 4,
  parameter int CNT_N    = 7,
  parameter int LONG_N   = 1000,
  parameter int REPEAT_N = 250
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [N_CH-1:0] i_in,
  output logic [N_CH-1:0] o_debounced,
  output logic [N_CH-1:0] o_pos,
  output logic [N_CH-1:0] o_neg,
  output logic [N_CH-1:0] o_long,
  output logic [N_CH-1:0] o_rep,
  output logic            o_any_pos
);

  localparam int CW = $clog2(CNT_N + 1);
  localparam int HW = $clog2(LONG_N + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(CNT_N);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_N);

  if (N_CH < 1 || CNT_N < 1 || LONG_N < 2 || REPEAT_N < 1) begin : g_bad_param
    $error("debounce_array: parameter out of range");
  end

  logic [N_CH-1:0] s1_q;
  logic [N_CH-1:0] s2_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= i_in;
      s2_q <= s1_q;
    end
  end

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    logic          state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          pos_q, pos_d;
    logic          neg_q, neg_d;
    logic          long_q, long_d;
    logic          toggle;

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      toggle  = 1'b0;
      if (s2_q[gi] == state_q) begin
        cnt_d = CNT_LOAD;
      end else if (cnt_q != '0) begin
        cnt_d = cnt_q - CW'(1);
      end else begin
        toggle  = 1'b1;
        state_d = ~state_q;
        cnt_d   = CNT_LOAD;
      end
      pos_d = toggle & ~state_q;
      neg_d = toggle & state_q;

      // A toggle in either direction wins over counting, so release on the
      // long-press edge itself suppresses o_long.
      hold_d = hold_q;
      long_d = 1'b0;
      if (toggle) begin
        hold_d = '0;
      end else if (state_q && hold_q != HOLD_MAX) begin
        hold_d = hold_q + HW'(1);
        long_d = (hold_q == HOLD_MAX - HW'(1));
      end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        state_q <= 1'b0;
        cnt_q   <= CNT_LOAD;
        hold_q  <= '0;
        pos_q   <= 1'b0;
        neg_q   <= 1'b0;
        long_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        hold_q  <= hold_d;
        pos_q   <= pos_d;
        neg_q   <= neg_d;
        long_q  <= long_d;
      end
    end

    assign o_debounced[gi] = state_q;
    assign o_pos[gi]       = pos_q;
    assign o_neg[gi]       = neg_q;
    assign o_long[gi]      = long_q;

`ifdef DEBOUNCE_ARRAY_REPEAT_EN
    localparam int RW = $clog2(REPEAT_N + 1);
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_N - 1);

    logic [RW-1:0] rep_cnt_q, rep_cnt_d;
    logic          rep_q, rep_d;

    // Saturated hold counter marks "long press already reported"; repeats run only then.
    always_comb begin
      rep_cnt_d = rep_cnt_q;
      rep_d     = 1'b0;
      if (toggle || long_d) begin
        rep_cnt_d = '0;
      end else if (state_q && hold_q == HOLD_MAX) begin
        if (rep_cnt_q == REP_LAST) begin
          rep_cnt_d = '0;
          rep_d     = 1'b1;
        end else begin
          rep_cnt_d = rep_cnt_q + RW'(1);
        end
      end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        rep_cnt_q <= '0;
        rep_q     <= 1'b0;
      end else begin
        rep_cnt_q <= rep_cnt_d;
        rep_q     <= rep_d;
      end
    end

    assign o_rep[gi] = rep_q;
`else
    assign o_rep[gi] = 1'b0;
`endif
  end

  assign o_any_pos = |o_pos;

endmodule

// File: tb/tb_debounce_array.sv
// Scoreboard bench for debounce_array: scenarios push expected pulse events, a monitor pops them whenever a pulse appears.
module tb_debounce_array;
  localparam int N_CH     = 4;
  localparam int CNT_N    = 3;
  localparam int LONG_N   = 20;
  localparam int REPEAT_N = 5;
  localparam int LAT      = CNT_N + 3;

  logic       i_clk   = 1'b0;
  logic       i_rst_n = 1'b0;
  logic [3:0] i_in    = 4'b0000;
  logic [3:0] o_debounced, o_pos, o_neg, o_long, o_rep;
  logic       o_any_pos;

  debounce_array #(
    .N_CH(N_CH), .CNT_N(CNT_N), .LONG_N(LONG_N), .REPEAT_N(REPEAT_N)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_in(i_in),
    .o_debounced(o_debounced), .o_pos(o_pos), .o_neg(o_neg),
    .o_long(o_long), .o_rep(o_rep), .o_any_pos(o_any_pos)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  typedef struct packed {
    int         c;
    logic [3:0] pos, neg, lng, rep, deb;
  } ev_t;

  ev_t q[$];
  ev_t e;
  int  checks = 0;
  int  errors = 0;

  function automatic void push(int c, logic [3:0] p, logic [3:0] n, logic [3:0] l,
                               logic [3:0] r, logic [3:0] d);
    ev_t x;
    x.c = c; x.pos = p; x.neg = n; x.lng = l; x.rep = r; x.deb = d;
    q.push_back(x);
  endfunction

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end else begin
      $display("ok   %s cyc=%0d value=%0h", name, cyc, act);
    end
  endfunction

  task automatic tick(int n);
    repeat (n) @(negedge i_clk);
  endtask

  // Monitor: every cycle that shows any pulse consumes exactly one expected event.
  always @(negedge i_clk) begin
    if (i_rst_n && (((o_pos | o_neg | o_long | o_rep) != 4'b0000) || o_any_pos)) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event cyc=%0d pos=%b neg=%b long=%b rep=%b deb=%b any=%b",
                 cyc, o_pos, o_neg, o_long, o_rep, o_debounced, o_any_pos);
      end else begin
        e = q.pop_front();
        if (e.c != cyc || o_pos !== e.pos || o_neg !== e.neg || o_long !== e.lng ||
            o_rep !== e.rep || o_debounced !== e.deb || o_any_pos !== (e.pos != 4'b0000)) begin
          errors++;
          $display("FAIL event got cyc=%0d pos=%b neg=%b long=%b rep=%b deb=%b any=%b want cyc=%0d pos=%b neg=%b long=%b rep=%b deb=%b",
                   cyc, o_pos, o_neg, o_long, o_rep, o_debounced, o_any_pos,
                   e.c, e.pos, e.neg, e.lng, e.rep, e.deb);
        end else begin
          $display("ok   event cyc=%0d pos=%b neg=%b long=%b rep=%b deb=%b",
                   cyc, o_pos, o_neg, o_long, o_rep, o_debounced);
        end
      end
    end
  end

  int p, p2, r;

  initial begin
    // Reset state
    tick(3);
    check("rst_deb", o_debounced, 0);
    check("rst_pos", o_pos, 0);
    check("rst_neg", o_neg, 0);
    check("rst_long", o_long, 0);
    check("rst_rep", o_rep, 0);
    check("rst_any", o_any_pos, 0);
    i_rst_n = 1'b1;

    // 1: idle then single press on ch0
    tick(50);
    check("idle_deb", o_debounced, 0);
    p = cyc + LAT;
    i_in = 4'b0001;
    push(p, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0001);
    tick(p + 5 - cyc);
    check("s1_deb_high", o_debounced, 4'b0001);
    push(cyc + LAT, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    i_in = 4'b0000;
    tick(20);

    // 2: bounce on ch1 never qualifies
    i_in[1] = 1'b1; tick(3);
    i_in[1] = 1'b0; tick(1);
    i_in[1] = 1'b1; tick(3);
    i_in[1] = 1'b0; tick(15);
    check("bounce_deb", o_debounced, 0);

    // 3: long press on ch2, release so that o_neg lands where a repeat would have
    p = cyc + LAT;
    i_in[2] = 1'b1;
    push(p,      4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0100);
    push(p + 20, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0100);
`ifdef DEBOUNCE_ARRAY_REPEAT_EN
    push(p + 25, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0100);
    push(p + 30, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0100);
    push(p + 35, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0100);
`endif
    push(p + 40, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0000);
    tick(p + 34 - cyc);
    check("s3_deb_held", o_debounced, 4'b0100);
    i_in[2] = 1'b0;
    tick(30);

    // 4: release one cycle short of long press on ch3, then re-press
    p = cyc + LAT;
    i_in[3] = 1'b1;
    push(p,      4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b1000);
    push(p + 20, 4'b0000, 4'b1000, 4'b0000, 4'b0000, 4'b0000);
    tick(p + 14 - cyc);
    i_in[3] = 1'b0;
    tick(9);
    p2 = cyc + LAT;
    i_in[3] = 1'b1;
    push(p2,      4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b1000);
    push(p2 + 20, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 4'b1000);
`ifdef DEBOUNCE_ARRAY_REPEAT_EN
    push(p2 + 25, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b1000);
`endif
    push(p2 + 28, 4'b0000, 4'b1000, 4'b0000, 4'b0000, 4'b0000);
    tick(p2 + 22 - cyc);
    i_in[3] = 1'b0;
    tick(20);

    // 5: simultaneous edges across channels
    p = cyc + LAT;
    i_in = 4'b1111;
    push(p,      4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b1111);
    push(p + 8,  4'b0000, 4'b1000, 4'b0000, 4'b0000, 4'b0111);
    push(p + 16, 4'b1000, 4'b0001, 4'b0000, 4'b0000, 4'b1110);
    push(p + 20, 4'b0000, 4'b1110, 4'b0000, 4'b0000, 4'b0000);
    tick(p + 2 - cyc);
    i_in = 4'b0111;
    tick(8);
    i_in = 4'b1110;
    tick(4);
    i_in = 4'b0000;
    tick(20);

    // 6: asynchronous reset mid-press, then re-qualification
    p = cyc + LAT;
    i_in = 4'b0001;
    push(p, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0001);
    tick(p + 10 - cyc);
    i_rst_n = 1'b0;
    #1;
    check("midrst_deb", o_debounced, 0);
    check("midrst_pos", o_pos, 0);
    check("midrst_neg", o_neg, 0);
    check("midrst_long", o_long, 0);
    check("midrst_rep", o_rep, 0);
    check("midrst_any", o_any_pos, 0);
    tick(3);
    r = cyc;
    i_rst_n = 1'b1;
    push(r + 6, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0001);
    tick(5);
    check("postrst_deb_low", o_debounced, 0);
    tick(5);
    push(cyc + LAT, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    i_in = 4'b0000;
    tick(25);

    check("events_left", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
